trng_fifo: RTL and testbench

Consumer-side front end for the TRNG register block. It drives the TRNG `gen` request and captures each `rdn` word on the `rdy` pulse. Captured words go into a small show-ahead FIFO, which a downstream client drains through a valid/ready port. The block discards the first post-reset word, because that word is the TRNG's reset value. It refills with watermark hysteresis and, optionally, rejects repeated words with a health check.

---
 rtl/trng_fifo_if.sv | 39 +++
 rtl/trng_fifo.sv | 114 +++++++++++
 tb/tb_trng_fifo.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trng_fifo_if.sv
// Bus bundle for trng_fifo: TRNG request/capture signals plus the show-ahead read port and status.
interface trng_fifo_if #(
  parameter int W     = 32,
  parameter int DEPTH = 4
);
  logic                   trng_gen;
  logic                   trng_rdy;
  logic [W-1:0]           trng_rdn;
  logic                   rd_vld;
  logic                   rd_rdy;
  logic [W-1:0]           rd_data;
  logic [$clog2(DEPTH):0] level;
  logic                   health_err;
  logic [7:0]             err_cnt;

  modport master (
    output trng_gen,
    input  trng_rdy,
    input  trng_rdn,
    output rd_vld,
    input  rd_rdy,
    output rd_data,
    output level,
    output health_err,
    output err_cnt
  );

  modport slave (
    input  trng_gen,
    output trng_rdy,
    output trng_rdn,
    input  rd_vld,
    output rd_rdy,
    input  rd_data,
    input  level,
    input  health_err,
    input  err_cnt
  );
endinterface

// File: rtl/trng_fifo.sv
// TRNG consumer front end: drops the first post-reset word, buffers the rest in a show-ahead FIFO with watermark refill.
// Word visible 1 cycle after trng_rdy; rd_rdy low holds the head, full FIFO drops trng_gen. TRNG_HEALTH_EN adds a repetition check.
module trng_fifo #(
  parameter int W      = 32,
  parameter int DEPTH  = 4,
  parameter int LOW_WM = 1
) (
  input logic         clk,
  input logic         rst,
  trng_fifo_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [1:0] PRIME = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic          gen_q;
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic [LW-1:0] level_nxt;
  logic          capture;
  logic          reject;
  logic          push;
  logic          pop;

  // Only FILL captures are candidates; PRIME's word is the TRNG reset value and WAIT words are stray.
  assign capture   = (state == FILL) && bus.trng_rdy;
  assign push      = capture && !reject;
  assign pop       = (level != '0) && bus.rd_rdy;
  assign level_nxt = level + LW'(push) - LW'(pop);

  always_comb begin
    state_nxt = state;
    case (state)
      PRIME:   if (bus.trng_rdy) state_nxt = FILL;
      FILL:    if (push && (level_nxt == LW'(DEPTH))) state_nxt = WAIT;
      WAIT:    if (level_nxt <= LW'(LOW_WM)) state_nxt = FILL;
      default: state_nxt = PRIME;
    endcase
  end

  // Request tracks the next state so it falls on the filling edge and rises on the refill edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= PRIME;
      gen_q <= 1'b0;
    end else begin
      state <= state_nxt;
      gen_q <= (state_nxt != WAIT);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= bus.trng_rdn;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      level <= level_nxt;
    end
  end

`ifdef TRNG_HEALTH_EN
  logic [W-1:0] last_word;
  logic         last_vld;
  logic         herr;
  logic [7:0]   ecnt;

  assign reject = capture && last_vld && (bus.trng_rdn == last_word);

  // Rejected words still become the comparison reference, so a stuck source keeps failing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_word <= '0;
      last_vld  <= 1'b0;
      herr      <= 1'b0;
      ecnt      <= '0;
    end else begin
      if (capture) begin
        last_word <= bus.trng_rdn;
        last_vld  <= 1'b1;
      end
      if (reject) begin
        herr <= 1'b1;
        if (ecnt != 8'hFF) ecnt <= ecnt + 8'd1;
      end
    end
  end

  assign bus.health_err = herr;
  assign bus.err_cnt    = ecnt;
`else
  assign reject         = 1'b0;
  assign bus.health_err = 1'b0;
  assign bus.err_cnt    = '0;
`endif

  assign bus.trng_gen = gen_q;
  assign bus.rd_vld   = (level != '0);
  assign bus.rd_data  = mem[rd_ptr];
  assign bus.level    = level;
endmodule

// File: tb/tb_trng_fifo.sv
// Bench for trng_fifo: TRNG model feeds a scoreboard queue, a negedge monitor checks level/vld/data, tasks check scenarios.
module tb_trng_fifo;
  localparam int W      = 32;
  localparam int DEPTH  = 4;
  localparam int LOW_WM = 1;
  localparam int LW     = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  trng_fifo_if #(.W(W), .DEPTH(DEPTH)) bus ();
  trng_fifo #(.W(W), .DEPTH(DEPTH), .LOW_WM(LOW_WM)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [W-1:0] exp_q [$];
  logic [W-1:0] vals  [$];
  bit           trng_en  = 1'b0;
  int           gap      = 2;
  int           rdy_cnt  = 0;
  int           cnt      = 0;
  logic [W-1:0] auto_val = 32'h0000_1000;
  bit           primed   = 1'b0;
  bit           pend     = 1'b0;
  bit           hv       = 1'b0;
  logic [W-1:0] pend_word;
  logic [W-1:0] hlast;

  // TRNG model: one rdy pulse after 'gap' idle cycles while gen is high; expected words enter the queue on capture.
  initial begin : trng_model
    logic [W-1:0] word;
    bit           drop;
    bus.trng_rdy = 1'b0;
    bus.trng_rdn = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.trng_rdy = 1'b0;
      bus.trng_rdn = $urandom();
      if (rst) begin
        pend   = 1'b0;
        primed = 1'b0;
        hv     = 1'b0;
        cnt    = 0;
      end else begin
        if (pend) begin
          exp_q.push_back(pend_word);
          pend = 1'b0;
        end
        if (trng_en && bus.trng_gen === 1'b1) begin
          if (cnt >= gap) begin
            if (vals.size() != 0) word = vals.pop_front();
            else begin
              word     = auto_val;
              auto_val = auto_val + 32'd1;
            end
            bus.trng_rdy = 1'b1;
            bus.trng_rdn = word;
            rdy_cnt++;
            cnt = 0;
            if (!primed) primed = 1'b1;
            else begin
              drop = 1'b0;
`ifdef TRNG_HEALTH_EN
              drop  = hv && (word == hlast);
              hlast = word;
              hv    = 1'b1;
`endif
              if (!drop) begin
                pend      = 1'b1;
                pend_word = word;
              end
            end
          end else cnt++;
        end else cnt = 0;
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      vectors++;
      if (bus.level !== LW'(exp_q.size())) begin
        miscompares++;
        $display("FAIL sb_level: got %0d want %0d at %0t", bus.level, exp_q.size(), $time);
      end
      vectors++;
      if (bus.rd_vld !== (exp_q.size() != 0)) begin
        miscompares++;
        $display("FAIL sb_vld: got %b want %b at %0t", bus.rd_vld, (exp_q.size() != 0), $time);
      end
      if (bus.rd_vld === 1'b1 && bus.rd_rdy === 1'b1 && exp_q.size() != 0) begin
        vectors++;
        if (bus.rd_data !== exp_q[0]) begin
          miscompares++;
          $display("FAIL sb_data: got %h want %h at %0t", bus.rd_data, exp_q[0], $time);
        end
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic test_reset();
    bit prev_gen;
    bit seen;
    int rc;
    #1;
    vectors++; if (bus.trng_gen !== 1'b0) begin miscompares++; $display("FAIL rst_gen: got %b want 0", bus.trng_gen); end
    vectors++; if (bus.rd_vld !== 1'b0) begin miscompares++; $display("FAIL rst_vld: got %b want 0", bus.rd_vld); end
    vectors++; if (bus.rd_data !== '0) begin miscompares++; $display("FAIL rst_data: got %h want 0", bus.rd_data); end
    vectors++; if (bus.level !== '0) begin miscompares++; $display("FAIL rst_level: got %0d want 0", bus.level); end
    vectors++; if (bus.health_err !== 1'b0) begin miscompares++; $display("FAIL rst_herr: got %b want 0", bus.health_err); end
    vectors++; if (bus.err_cnt !== 8'd0) begin miscompares++; $display("FAIL rst_ecnt: got %0d want 0", bus.err_cnt); end
    vals    = '{32'h0, 32'h11, 32'h22, 32'h33, 32'h44};
    trng_en = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    @(negedge clk);
    vectors++; if (bus.trng_gen !== 1'b0) begin miscompares++; $display("FAIL gen_pre_edge: got %b want 0", bus.trng_gen); end
    @(negedge clk);
    vectors++; if (bus.trng_gen !== 1'b1) begin miscompares++; $display("FAIL gen_first_edge: got %b want 1", bus.trng_gen); end
    prev_gen = 1'b1;
    seen     = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (bus.level === LW'(4)) seen = 1'b1;
      else prev_gen = bus.trng_gen;
    end
    vectors++; if (!seen) begin miscompares++; $display("FAIL fill_timeout: level %0d want 4", bus.level); end
    vectors++; if ({prev_gen, bus.trng_gen} !== 2'b10) begin miscompares++; $display("FAIL full_gen_fall: got %b want 10", {prev_gen, bus.trng_gen}); end
    vectors++; if (bus.rd_data !== 32'h11) begin miscompares++; $display("FAIL first_head: got %h want 11", bus.rd_data); end
    rc = rdy_cnt;
    repeat (20) @(negedge clk);
    vectors++; if (rdy_cnt !== 5) begin miscompares++; $display("FAIL rdy_consumed: got %0d want 5 (was %0d)", rdy_cnt, rc); end
    vectors++; if (bus.level !== LW'(4)) begin miscompares++; $display("FAIL full_hold: got %0d want 4", bus.level); end
  endtask

  task automatic test_pop_refill();
    logic [W-1:0] tbl [3] = '{32'h11, 32'h22, 32'h33};
    bit seen;
    vals = '{32'h55, 32'h66, 32'h77};
    @(posedge clk); #1 bus.rd_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++; if (bus.rd_data !== tbl[i]) begin miscompares++; $display("FAIL pop_data%0d: got %h want %h", i, bus.rd_data, tbl[i]); end
      vectors++; if (bus.trng_gen !== 1'b0) begin miscompares++; $display("FAIL pop_gen%0d: got %b want 0", i, bus.trng_gen); end
      @(posedge clk);
    end
    #1 bus.rd_rdy = 1'b0;
    @(negedge clk);
    vectors++; if (bus.level !== LW'(1)) begin miscompares++; $display("FAIL lowwm_level: got %0d want 1", bus.level); end
    vectors++; if (bus.trng_gen !== 1'b1) begin miscompares++; $display("FAIL refill_gen: got %b want 1", bus.trng_gen); end
    vectors++; if (bus.rd_data !== 32'h44) begin miscompares++; $display("FAIL refill_head: got %h want 44", bus.rd_data); end
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (bus.level === LW'(4)) seen = 1'b1;
    end
    vectors++; if (!seen || bus.trng_gen !== 1'b0) begin miscompares++; $display("FAIL refill_full: level %0d gen %b want 4/0", bus.level, bus.trng_gen); end
  endtask

  task automatic test_back_to_back();
    bit seen;
    @(negedge clk); gap = 0;
    @(posedge clk); #1 bus.rd_rdy = 1'b1;
    repeat (8) @(posedge clk);
    #1 bus.rd_rdy = 1'b0;
    @(posedge clk); #1 bus.rd_rdy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vectors++; if (bus.level !== LW'(2) || bus.trng_gen !== 1'b1) begin miscompares++; $display("FAIL b2b_level%0d: level %0d gen %b want 2/1", i, bus.level, bus.trng_gen); end
    end
    @(posedge clk); #1 bus.rd_rdy = 1'b0;
    @(negedge clk); gap = 2;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (bus.level === LW'(4)) seen = 1'b1;
    end
    vectors++; if (!seen) begin miscompares++; $display("FAIL b2b_refill: got %0d want 4", bus.level); end
  endtask

  task automatic test_async_reset();
    bit seen;
    @(posedge clk); #1 bus.rd_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1 bus.rd_rdy = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (bus.level === LW'(2) && bus.trng_gen === 1'b1) seen = 1'b1;
    end
    vectors++; if (!seen) begin miscompares++; $display("FAIL arst_setup: level %0d gen %b want 2/1", bus.level, bus.trng_gen); end
    #2 rst = 1'b1;
    exp_q.delete();
    vals.delete();
    vals = '{32'h99, 32'hC1, 32'hC2};
    #1;
    vectors++; if (bus.trng_gen !== 1'b0) begin miscompares++; $display("FAIL arst_gen: got %b want 0", bus.trng_gen); end
    vectors++; if (bus.level !== '0 || bus.rd_vld !== 1'b0) begin miscompares++; $display("FAIL arst_level: level %0d vld %b want 0/0", bus.level, bus.rd_vld); end
    vectors++; if (bus.rd_data !== '0) begin miscompares++; $display("FAIL arst_data: got %h want 0", bus.rd_data); end
    @(posedge clk); #2 rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (bus.level !== '0) seen = 1'b1;
    end
    vectors++; if (!seen || bus.rd_data !== 32'hC1) begin miscompares++; $display("FAIL arst_prime: got %h want c1", bus.rd_data); end
  endtask

  task automatic test_health();
    bit seen;
    logic [7:0]   exp_cnt;
    logic         exp_err;
    logic [W-1:0] exp_second;
`ifdef TRNG_HEALTH_EN
    exp_cnt = 8'd1; exp_err = 1'b1; exp_second = 32'hBB;
`else
    exp_cnt = 8'd0; exp_err = 1'b0; exp_second = 32'hAA;
`endif
    @(negedge clk); #2 rst = 1'b1;
    exp_q.delete();
    vals.delete();
    vals = '{32'h0, 32'hAA, 32'hAA, 32'hBB};
    @(posedge clk); #2 rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (bus.level === LW'(4)) seen = 1'b1;
    end
    vectors++; if (!seen) begin miscompares++; $display("FAIL health_fill: got %0d want 4", bus.level); end
    vectors++; if (bus.err_cnt !== exp_cnt) begin miscompares++; $display("FAIL health_cnt: got %0d want %0d", bus.err_cnt, exp_cnt); end
    vectors++; if (bus.health_err !== exp_err) begin miscompares++; $display("FAIL health_err: got %b want %b", bus.health_err, exp_err); end
    @(posedge clk); #1 bus.rd_rdy = 1'b1;
    @(negedge clk);
    vectors++; if (bus.rd_data !== 32'hAA) begin miscompares++; $display("FAIL health_w0: got %h want aa", bus.rd_data); end
    @(negedge clk);
    vectors++; if (bus.rd_data !== exp_second) begin miscompares++; $display("FAIL health_w1: got %h want %h", bus.rd_data, exp_second); end
  endtask

  task automatic test_underflow();
    bit seen;
    logic exp_err;
`ifdef TRNG_HEALTH_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    @(negedge clk); trng_en = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (bus.level === '0) seen = 1'b1;
    end
    vectors++; if (!seen) begin miscompares++; $display("FAIL drain_timeout: got %0d want 0", bus.level); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vectors++; if (bus.rd_vld !== 1'b0 || bus.level !== '0) begin miscompares++; $display("FAIL underflow%0d: vld %b level %0d want 0/0", i, bus.rd_vld, bus.level); end
    end
    vectors++; if (bus.health_err !== exp_err) begin miscompares++; $display("FAIL health_sticky: got %b want %b", bus.health_err, exp_err); end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bus.rd_rdy = 1'b0;
    test_reset();
    test_pop_refill();
    test_back_to_back();
    test_async_reset();
    test_health();
    test_underflow();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
